// File: rtl/ysyx_25040129_ifq.sv
// Prefetching instruction-fetch queue between the AXI-lite I-port and the IDU.
// Define YSYX_25040129_IFQ_PERF_EN to add the perf_fetch_cnt/perf_drop_cnt outputs.
module ysyx_25040129_ifq #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        csr_hazard,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
`ifdef YSYX_25040129_IFQ_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W:0]   ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        drop_cnt_q, drop_cnt_d;
    logic        ar_stale_q, ar_stale_d;
    logic        ar_pend_q, ar_pend_d;
    logic [31:0] araddr_q, araddr_d;
    ptr_t        wptr_q, wptr_d;
    ptr_t        rptr_q, rptr_d;

    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic        mem_err  [DEPTH];

    cnt_t fifo_count;
    logic fifo_empty;
    logic issue_ok;
    logic ar_fire;
    logic r_fire;
    logic drop_now;
    logic push;
    logic pop;

    assign fifo_count = cnt_t'(wptr_q - rptr_q);
    assign fifo_empty = (wptr_q == rptr_q);

    // Credit check counts in-flight reads against free slots so a response never finds the FIFO full.
    assign issue_ok = !rst && !flush && !csr_hazard
                      && (outstanding_q < cnt_t'(MAX_OUTSTANDING))
                      && ((outstanding_q + fifo_count) < cnt_t'(DEPTH));

    assign arvalid  = !rst && (ar_pend_q || issue_ok);
    assign araddr   = ar_pend_q ? araddr_q : fetch_pc_q;
    assign rready   = !rst;
    assign ar_fire  = arvalid && arready;
    assign r_fire   = rvalid && rready;
    assign drop_now = r_fire && (flush || (drop_cnt_q != '0));
    assign push     = r_fire && !drop_now;

    assign out_valid = !rst && !fifo_empty && !flush && !csr_hazard;
    assign pop       = out_valid && out_ready;
    assign out_pc    = (rst || fifo_empty) ? RESET_PC : mem_pc[rptr_q[PTR_W-1:0]];
    assign out_inst  = (rst || fifo_empty) ? 32'h0    : mem_inst[rptr_q[PTR_W-1:0]];
    assign out_err   = (rst || fifo_empty) ? 1'b0     : mem_err[rptr_q[PTR_W-1:0]];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + cnt_t'(ar_fire) - cnt_t'(r_fire);
        drop_cnt_d    = drop_cnt_q;
        ar_stale_d    = ar_stale_q;
        ar_pend_d     = arvalid && !arready;
        araddr_d      = araddr_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;

        if (arvalid && !ar_pend_q) begin
            araddr_d = fetch_pc_q;
        end

        if (flush) begin
            fetch_pc_d = flush_target;
            resp_pc_d  = flush_target;
            // Responses landing this cycle are already gone from outstanding_d.
            drop_cnt_d = outstanding_d;
            ar_stale_d = ar_pend_d;
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            if (ar_fire && !ar_stale_q) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            drop_cnt_d = drop_cnt_q - cnt_t'(drop_now) + cnt_t'(ar_fire && ar_stale_q);
            if (ar_fire) begin
                ar_stale_d = 1'b0;
            end
            wptr_d = wptr_q + ptr_t'(push);
            rptr_d = rptr_q + ptr_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            ar_stale_q    <= 1'b0;
            ar_pend_q     <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            ar_stale_q    <= ar_stale_d;
            ar_pend_q     <= ar_pend_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        araddr_q <= araddr_d;
        if (push) begin
            mem_pc[wptr_q[PTR_W-1:0]]   <= resp_pc_q;
            mem_inst[wptr_q[PTR_W-1:0]] <= rdata;
            mem_err[wptr_q[PTR_W-1:0]]  <= (rresp != 2'b00);
        end
    end

`ifdef YSYX_25040129_IFQ_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(pop);
            perf_drop_q  <= perf_drop_q + 32'(drop_now);
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_ysyx_25040129_ifq.sv
// Scoreboard bench for ysyx_25040129_ifq: AXI-lite memory model, expected-PC queue, directed and random phases.
module tb_ysyx_25040129_ifq;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_target = 32'h0;
    logic        csr_hazard = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
`ifdef YSYX_25040129_IFQ_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    ysyx_25040129_ifq #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_target(flush_target),
        .csr_hazard(csr_hazard), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_err(out_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef YSYX_25040129_IFQ_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic bit err_of(input logic [31:0] a);
        return a[4:2] == 3'b010;
    endfunction

    // Scoreboard: the instruction stream the IDU must see from the latest redirect on.
    logic [31:0] exp_q[$];
    int pop_cyc[$];
    int pops_since_rst = 0;

    task automatic redirect(input logic [31:0] target);
        exp_q.delete();
        for (int i = 0; i < 200; i++) exp_q.push_back(target + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            pops_since_rst = 0;
            check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 0);
            check(arvalid == 1'b0, "rst_arvalid", 32'(arvalid), 0);
            check(rready == 1'b0, "rst_rready", 32'(rready), 0);
            check(out_pc == RESET_PC, "rst_out_pc", out_pc, RESET_PC);
            check(out_inst == 32'h0, "rst_out_inst", out_inst, 0);
            check(out_err == 1'b0, "rst_out_err", 32'(out_err), 0);
        end else begin
            if (flush || csr_hazard) check(!out_valid, "blocked_out_valid", 32'(out_valid), 0);
            if (out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                pops_since_rst++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "sb_unexpected_pop", out_pc, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(out_pc == e, "sb_pc", out_pc, e);
                    check(out_inst == inst_of(e), "sb_inst", out_inst, inst_of(e));
                    check(out_err == err_of(e), "sb_err", 32'(out_err), 32'(err_of(e)));
                end
            end
        end
    end

    // AXI-lite memory model: in-order responses after mem_lat cycles, epoch tags identify stale reads.
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } rd_t;
    rd_t rq[$];
    int ar_mode = 0;
    bit r_rand = 1'b0;
    int mem_lat = 1;
    int epoch = 0;
    int drop_exp = 0;
    int ar_cnt = 0;
    logic [31:0] ar_log[$];
    bit prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int pend_ep = 0;

    always @(negedge clk) begin
        rd_t r;
        if (rst) begin
            rq.delete();
            prev_pend = 1'b0;
            drop_exp = 0;
            epoch = 0;
        end else begin
            if (prev_pend) begin
                check(arvalid == 1'b1, "ar_hold_valid", 32'(arvalid), 1);
                check(araddr == prev_addr, "ar_hold_addr", araddr, prev_addr);
            end
            if ((flush || csr_hazard) && arvalid) check(prev_pend, "ar_rise_blocked", 32'(arvalid), 0);
            if (arvalid && !prev_pend) pend_ep = epoch;
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    check(1'b0, "spurious_r", 32'(rvalid), 0);
                end else begin
                    r = rq.pop_front();
                    if (flush || r.ep != epoch) drop_exp++;
                end
            end
            if (arvalid && arready) begin
                r.addr = araddr;
                r.due = cyc + mem_lat;
                r.ep = pend_ep;
                rq.push_back(r);
                ar_cnt++;
                ar_log.push_back(araddr);
            end
            check(rq.size() <= MAXO, "outstanding_max", 32'(rq.size()), MAXO);
            prev_pend = arvalid && !arready;
            prev_addr = araddr;
            if (flush) epoch++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ar_mode)
            0:       arready = 1'b1;
            1:       arready = ($urandom_range(0, 1) == 1);
            default: arready = 1'b0;
        endcase
        if (rq.size() > 0 && rq[0].due <= cyc && (!r_rand || $urandom_range(0, 3) != 0)) begin
            rvalid = 1'b1;
            rdata = inst_of(rq[0].addr);
            rresp = err_of(rq[0].addr) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata = 32'h0;
            rresp = 2'b00;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        step();
        rst = 1'b1;
        flush = 1'b0;
        csr_hazard = 1'b0;
        repeat (n) step();
        rst = 1'b0;
        redirect(RESET_PC);
        pop_cyc.delete();
    endtask

    task automatic check_consecutive(input int base, input int n, input string name);
        check(pop_cyc.size() >= base + n, {name, "_count"}, 32'(pop_cyc.size()), 32'(base + n));
        if (pop_cyc.size() >= base + n)
            for (int i = 1; i < n; i++)
                check(pop_cyc[base + i] == pop_cyc[base + i - 1] + 1, {name, "_gap"},
                      32'(pop_cyc[base + i]), 32'(pop_cyc[base + i - 1] + 1));
    endtask

    initial begin
        int a0;
        int b;
        int k;
        int p0;
        int l0;
        logic [31:0] held;
        logic [31:0] t;
        logic [31:0] d0;

        // Boot: first AR to RESET_PC right after reset, then one pop per cycle.
        mem_lat = 1;
        out_ready = 1'b1;
        do_reset(3);
        @(negedge clk);
        check(arvalid == 1'b1, "boot_arvalid", 32'(arvalid), 1);
        check(araddr == RESET_PC, "boot_araddr", araddr, RESET_PC);
        repeat (15) step();
        check_consecutive(0, 3, "boot_stream");

        // Backpressure: exactly DEPTH reads issued, then AR idles; release drains in order without gaps.
        out_ready = 1'b0;
        do_reset(2);
        a0 = ar_cnt;
        repeat (20) step();
        @(negedge clk);
        check(ar_cnt - a0 == DEPTH, "bp_ar_count", 32'(ar_cnt - a0), DEPTH);
        check(arvalid == 1'b0, "bp_arvalid_idle", 32'(arvalid), 0);
        b = pop_cyc.size();
        step();
        out_ready = 1'b1;
        repeat (8) step();
        check_consecutive(b, 4, "bp_release");

        // Flush with two reads in flight at latency 3.
        mem_lat = 3;
        do_reset(2);
        repeat (12) step();
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (rq.size() != 2 && k < 30);
        check(rq.size() == 2, "fl_two_inflight", 32'(rq.size()), 2);
        step();
`ifdef YSYX_25040129_IFQ_PERF_EN
        d0 = perf_drop_cnt;
`else
        d0 = 32'h0;
`endif
        p0 = pops_since_rst;
        flush = 1'b1;
        flush_target = 32'h8000_0100;
        redirect(32'h8000_0100);
        step();
        flush = 1'b0;
        repeat (20) step();
        check(pops_since_rst > p0, "fl_resumed", 32'(pops_since_rst), 32'(p0 + 1));
`ifdef YSYX_25040129_IFQ_PERF_EN
        check(perf_drop_cnt - d0 == 32'd2, "fl_perf_drop", perf_drop_cnt - d0, 2);
`endif

        // Flush while an AR is stalled: address holds, its response is dropped, then AR to the target.
        mem_lat = 2;
        repeat (4) step();
        ar_mode = 2;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(arvalid && !arready) && k < 20);
        check(arvalid && !arready, "st_pending", 32'(arvalid), 1);
        held = araddr;
        step();
        flush = 1'b1;
        flush_target = 32'h8000_0200;
        redirect(32'h8000_0200);
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(arvalid && araddr == held, "st_hold", araddr, held);
        end
        #1;
        l0 = ar_log.size();
        step();
        ar_mode = 0;
        repeat (12) step();
        check(ar_log.size() >= l0 + 2, "st_ar_count", 32'(ar_log.size()), 32'(l0 + 2));
        if (ar_log.size() >= l0 + 2) begin
            check(ar_log[l0] == held, "st_first_ar", ar_log[l0], held);
            check(ar_log[l0 + 1] == 32'h8000_0200, "st_target_ar", ar_log[l0 + 1], 32'h8000_0200);
        end

        // SATP hazard for 5 cycles with a full FIFO.
        out_ready = 1'b0;
        repeat (12) step();
        @(negedge clk);
        check(out_valid == 1'b1, "hz_nonempty", 32'(out_valid), 1);
        step();
        csr_hazard = 1'b1;
        out_ready = 1'b1;
        p0 = pops_since_rst;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(!out_valid, "hz_out_valid", 32'(out_valid), 0);
            check(!arvalid, "hz_arvalid", 32'(arvalid), 0);
            step();
        end
        csr_hazard = 1'b0;
        check(pops_since_rst == p0, "hz_no_pop", 32'(pops_since_rst), 32'(p0));
        repeat (10) step();
        check(pops_since_rst >= p0 + 4, "hz_resume", 32'(pops_since_rst), 32'(p0 + 4));

        // Random traffic with redirects, back-to-back flushes, PC wrap and a mid-run reset.
        ar_mode = 1;
        r_rand = 1'b1;
        for (int s = 0; s < 25; s++) begin
            mem_lat = $urandom_range(1, 4);
            for (int c = 0, n = $urandom_range(20, 100); c < n; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                csr_hazard = ($urandom_range(0, 9) == 0);
                step();
            end
            if (s == 12) begin
                do_reset(2);
            end else begin
                csr_hazard = 1'b0;
                t = $urandom();
                t[1:0] = 2'b00;
                if (s == 5) t = 32'hFFFF_FFF0;
                flush = 1'b1;
                flush_target = t;
                redirect(t);
                step();
                if (s % 4 == 1) begin
                    t = t + 32'h0000_1000;
                    flush_target = t;
                    redirect(t);
                    step();
                end
                flush = 1'b0;
            end
        end

        // Idle out so counters settle, then compare them with the bench's own tallies.
        out_ready = 1'b0;
        csr_hazard = 1'b0;
        repeat (25) step();
        @(negedge clk);
        #1;
        check(rq.size() == 0, "end_drained", 32'(rq.size()), 0);
`ifdef YSYX_25040129_IFQ_PERF_EN
        check(perf_drop_cnt == 32'(drop_exp), "perf_drop_total", perf_drop_cnt, 32'(drop_exp));
        check(perf_fetch_cnt == 32'(pops_since_rst), "perf_fetch_total", perf_fetch_cnt, 32'(pops_since_rst));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
